// File: rtl/elevator_pkg.sv
// Shared definitions for the elevator SCAN controller.
//   elev_state_t : controller state encoding
//   ELEV_DEF_*   : default parameter values used by elevator_scan_ctrl
//   elev_max     : helper used to size the shared timer
package elevator_pkg;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_MOVE_UP   = 2'd1,
    S_MOVE_DOWN = 2'd2,
    S_DOOR      = 2'd3
  } elev_state_t;

  localparam int ELEV_DEF_N_FLOORS    = 8;
  localparam int ELEV_DEF_MOVE_CYCLES = 4;
  localparam int ELEV_DEF_DOOR_CYCLES = 3;

  function automatic int elev_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/elev_timer.sv
// Loadable down-counter shared by the travel and door-dwell phases.
//   clk, rst  : clock, synchronous active-high reset (count cleared)
//   load      : load load_val this cycle (takes priority over counting)
//   load_val  : value to load
//   done      : high during the last cycle of a loaded interval (count == 1)
module elev_timer #(
  parameter int TW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [TW-1:0] load_val,
  output logic          done
);

  logic [TW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - TW'(1);
    end
  end

  // A value of N loaded at one edge yields done in the Nth following cycle.
  assign done = (cnt == TW'(1));

endmodule

// File: rtl/elevator_scan_ctrl.sv
// Single-car elevator controller using the SCAN (elevator) algorithm.
//   clk, rst   : clock, synchronous active-high reset
//   req_valid  : a floor request is present this cycle
//   req_floor  : requested floor (values >= N_FLOORS are ignored)
//   door_hold  : (only when ELEV_DOOR_HOLD_EN is defined) keeps the door open
//   floor_pos  : current floor
//   pending    : latched requests, one bit per floor
//   dir_up     : travel direction, 1 = up
//   moving     : car is travelling
//   door_open  : door is open
//   arrive     : one-cycle pulse in the first door-open cycle
// Build option: define ELEV_DOOR_HOLD_EN to add the door_hold input.
module elevator_scan_ctrl
  import elevator_pkg::*;
#(
  parameter int  N_FLOORS    = ELEV_DEF_N_FLOORS,
  parameter int  MOVE_CYCLES = ELEV_DEF_MOVE_CYCLES,
  parameter int  DOOR_CYCLES = ELEV_DEF_DOOR_CYCLES,
  localparam int FW          = $clog2(N_FLOORS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  input  logic [FW-1:0]       req_floor,
`ifdef ELEV_DOOR_HOLD_EN
  input  logic                door_hold,
`endif
  output logic [FW-1:0]       floor_pos,
  output logic [N_FLOORS-1:0] pending,
  output logic                dir_up,
  output logic                moving,
  output logic                door_open,
  output logic                arrive
);

  localparam int            TW     = $clog2(elev_max(MOVE_CYCLES, DOOR_CYCLES) + 1);
  localparam logic [TW-1:0] MOVE_T = TW'(MOVE_CYCLES);
  localparam logic [TW-1:0] DOOR_T = TW'(DOOR_CYCLES);

  elev_state_t         state, state_nxt;
  logic [FW-1:0]       floor_nxt, step_floor;
  logic [N_FLOORS-1:0] pending_nxt, above_mask, below_mask, set_mask, clr_mask;
  logic                any_above, any_below;
  logic                dir_nxt, door_entry, hold;
  logic                tmr_load, tmr_done;
  logic [TW-1:0]       tmr_val;

`ifdef ELEV_DOOR_HOLD_EN
  assign hold = door_hold;
`else
  assign hold = 1'b0;
`endif

  // Floors above/below the car, and the incoming request as a one-hot mask.
  // Out-of-range request indices never match any floor and drop out here.
  always_comb begin
    above_mask = '0;
    below_mask = '0;
    set_mask   = '0;
    for (int i = 0; i < N_FLOORS; i++) begin
      above_mask[i] = (FW'(i) > floor_pos);
      below_mask[i] = (FW'(i) < floor_pos);
      set_mask[i]   = req_valid && (FW'(i) == req_floor);
    end
  end

  assign any_above  = |(pending & above_mask);
  assign any_below  = |(pending & below_mask);
  assign step_floor = (state == S_MOVE_UP) ? floor_pos + FW'(1) : floor_pos - FW'(1);

  always_comb begin
    state_nxt  = state;
    floor_nxt  = floor_pos;
    dir_nxt    = dir_up;
    door_entry = 1'b0;
    tmr_load   = 1'b0;
    tmr_val    = MOVE_T;
    case (state)
      S_IDLE: begin
        if (pending[floor_pos]) begin
          state_nxt  = S_DOOR;
          door_entry = 1'b1;
          tmr_load   = 1'b1;
          tmr_val    = DOOR_T;
        end else if (any_above) begin
          state_nxt = S_MOVE_UP;
          dir_nxt   = 1'b1;
          tmr_load  = 1'b1;
        end else if (any_below) begin
          state_nxt = S_MOVE_DOWN;
          dir_nxt   = 1'b0;
          tmr_load  = 1'b1;
        end
      end
      S_MOVE_UP, S_MOVE_DOWN: begin
        if (tmr_done) begin
          floor_nxt = step_floor;
          tmr_load  = 1'b1;
          if (pending[step_floor]) begin
            state_nxt  = S_DOOR;
            door_entry = 1'b1;
            tmr_val    = DOOR_T;
          end
        end
      end
      S_DOOR: begin
        if (hold) begin
          tmr_load = 1'b1;
          tmr_val  = DOOR_T;
        end else if (tmr_done) begin
          // SCAN: keep going the current way while work remains there.
          if (dir_up ? any_above : any_below) begin
            state_nxt = dir_up ? S_MOVE_UP : S_MOVE_DOWN;
            tmr_load  = 1'b1;
          end else if (dir_up ? any_below : any_above) begin
            dir_nxt   = ~dir_up;
            state_nxt = dir_up ? S_MOVE_DOWN : S_MOVE_UP;
            tmr_load  = 1'b1;
          end else begin
            state_nxt = S_IDLE;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // The served floor is cleared on door entry and held clear while the door
  // is open, so a request for it is absorbed. Requests for other floors are
  // unaffected by the clear.
  always_comb begin
    clr_mask = '0;
    for (int i = 0; i < N_FLOORS; i++) begin
      clr_mask[i] = (door_entry || (state == S_DOOR)) && (FW'(i) == floor_nxt);
    end
  end

  assign pending_nxt = (pending | set_mask) & ~clr_mask;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      floor_pos <= '0;
      pending   <= '0;
      dir_up    <= 1'b1;
      arrive    <= 1'b0;
    end else begin
      state     <= state_nxt;
      floor_pos <= floor_nxt;
      pending   <= pending_nxt;
      dir_up    <= dir_nxt;
      arrive    <= door_entry;
    end
  end

  assign moving    = (state == S_MOVE_UP) || (state == S_MOVE_DOWN);
  assign door_open = (state == S_DOOR);

  elev_timer #(
    .TW (TW)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

endmodule

// File: tb/tb_elevator_scan_ctrl.sv
// Testbench for elevator_scan_ctrl: directed scenarios plus a randomized run
// compared cycle by cycle against a rule-level reference model.
module tb_elevator_scan_ctrl;

  localparam int N   = 8;
  localparam int MV  = 4;
  localparam int DC  = 3;
  localparam int FW  = $clog2(N);
  localparam int SN  = 6;
  localparam int SFW = $clog2(SN);

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic [FW-1:0] req_floor;
`ifdef ELEV_DOOR_HOLD_EN
  logic          door_hold;
`endif
  logic [FW-1:0] floor_pos;
  logic [N-1:0]  pending;
  logic          dir_up, moving, door_open, arrive;

  logic           s_req_valid;
  logic [SFW-1:0] s_req_floor;
  logic [SFW-1:0] s_floor_pos;
  logic [SN-1:0]  s_pending;
  logic           s_dir_up, s_moving, s_door_open, s_arrive;

  int errors = 0;
  int checks = 0;

  // Reference model: mode 0 idle, 1 up, 2 down, 3 door; m_el counts cycles
  // spent in the current floor leg or door dwell.
  int m_floor, m_mode, m_el;
  bit m_dir, m_arr;
  bit m_pend [N];

  always #5 clk = ~clk;

  elevator_scan_ctrl #(.N_FLOORS(N), .MOVE_CYCLES(MV), .DOOR_CYCLES(DC)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_floor(req_floor),
`ifdef ELEV_DOOR_HOLD_EN
    .door_hold(door_hold),
`endif
    .floor_pos(floor_pos), .pending(pending), .dir_up(dir_up),
    .moving(moving), .door_open(door_open), .arrive(arrive)
  );

  elevator_scan_ctrl #(.N_FLOORS(SN), .MOVE_CYCLES(MV), .DOOR_CYCLES(DC)) dut_small (
    .clk(clk), .rst(rst), .req_valid(s_req_valid), .req_floor(s_req_floor),
`ifdef ELEV_DOOR_HOLD_EN
    .door_hold(1'b0),
`endif
    .floor_pos(s_floor_pos), .pending(s_pending), .dir_up(s_dir_up),
    .moving(s_moving), .door_open(s_door_open), .arrive(s_arrive)
  );

  function automatic bit req_in_dir(input bit up);
    for (int i = 0; i < N; i++)
      if (m_pend[i] && (up ? (i > m_floor) : (i < m_floor))) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [N-1:0] pend_vec();
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = m_pend[i];
    return v;
  endfunction

  task automatic model_step(input bit r, input bit v, input int f, input bit h);
    int  old_mode;
    bit  door_now;
    if (r) begin
      m_floor = 0; m_mode = 0; m_el = 0; m_dir = 1'b1; m_arr = 1'b0;
      for (int i = 0; i < N; i++) m_pend[i] = 1'b0;
      return;
    end
    old_mode = m_mode;
    door_now = 1'b0;
    case (m_mode)
      0: begin
        if (m_pend[m_floor]) door_now = 1'b1;
        else if (req_in_dir(1'b1)) begin m_mode = 1; m_dir = 1'b1; m_el = 0; end
        else if (req_in_dir(1'b0)) begin m_mode = 2; m_dir = 1'b0; m_el = 0; end
      end
      1, 2: begin
        m_el++;
        if (m_el == MV) begin
          m_floor += (m_mode == 1) ? 1 : -1;
          m_el = 0;
          if (m_pend[m_floor]) door_now = 1'b1;
        end
      end
      default: begin
        if (h) m_el = 0;
        else begin
          m_el++;
          if (m_el == DC) begin
            m_el = 0;
            if (req_in_dir(m_dir)) m_mode = m_dir ? 1 : 2;
            else if (req_in_dir(!m_dir)) begin m_dir = !m_dir; m_mode = m_dir ? 1 : 2; end
            else m_mode = 0;
          end
        end
      end
    endcase
    if (door_now) begin m_mode = 3; m_el = 0; m_pend[m_floor] = 1'b0; end
    m_arr = door_now;
    if (v && f >= 0 && f < N && !((old_mode == 3 || door_now) && f == m_floor))
      m_pend[f] = 1'b1;
  endtask

  task automatic tick(input bit r, input bit v, input int f, input bit h);
    rst = r; req_valid = v; req_floor = f[FW-1:0];
`ifdef ELEV_DOOR_HOLD_EN
    door_hold = h;
`endif
    @(posedge clk);
    model_step(r, v, f, h);
    #1;
  endtask

  task automatic test_reset();
    s_req_valid = 1'b0; s_req_floor = '0;
    tick(1, 0, 0, 0);
    tick(1, 1, 3, 0);
    checks++; if (floor_pos !== '0) begin errors++; $display("FAIL reset_floor got=%0d exp=0", floor_pos); end
    checks++; if (pending !== '0) begin errors++; $display("FAIL reset_pending got=%b exp=0", pending); end
    checks++; if (dir_up !== 1'b1) begin errors++; $display("FAIL reset_dir got=%b exp=1", dir_up); end
    checks++; if (moving !== 1'b0) begin errors++; $display("FAIL reset_moving got=%b exp=0", moving); end
    checks++; if (door_open !== 1'b0) begin errors++; $display("FAIL reset_door got=%b exp=0", door_open); end
    checks++; if (arrive !== 1'b0) begin errors++; $display("FAIL reset_arrive got=%b exp=0", arrive); end
  endtask

  task automatic test_travel_to_5();
    int n;
    tick(0, 1, 5, 0);
    tick(0, 0, 0, 0);
    checks++; if (moving !== 1'b1 || dir_up !== 1'b1) begin
      errors++; $display("FAIL start_up got moving=%b dir=%b exp 1/1", moving, dir_up); end
    n = 0;
    while (floor_pos !== FW'(5) && n < 200) begin tick(0, 0, 0, 0); n++; end
    checks++; if (n != 5 * MV) begin errors++; $display("FAIL travel_cycles got=%0d exp=%0d", n, 5 * MV); end
    checks++; if (arrive !== 1'b1 || door_open !== 1'b1) begin
      errors++; $display("FAIL arrive_5 got arrive=%b door=%b exp 1/1", arrive, door_open); end
    checks++; if (pending[5] !== 1'b0) begin errors++; $display("FAIL clear_5 got=%b exp=0", pending[5]); end
  endtask

  task automatic test_scan_order();
    int q[$];
    tick(0, 1, 2, 0);
    if (arrive) q.push_back(int'(floor_pos));
    tick(0, 1, 7, 0);
    if (arrive) q.push_back(int'(floor_pos));
    for (int k = 0; k < 400 && q.size() < 2; k++) begin
      tick(0, 0, 0, 0);
      if (arrive) q.push_back(int'(floor_pos));
    end
    checks++;
    if (q.size() != 2) begin errors++; $display("FAIL scan_count got=%0d exp=2", q.size()); end
    else if (q[0] != 7 || q[1] != 2) begin
      errors++; $display("FAIL scan_order got=%0d,%0d exp=7,2", q[0], q[1]); end
  endtask

  task automatic test_same_floor();
    int fl;
    bit seen;
    for (int k = 0; k < 50 && m_mode != 0; k++) tick(0, 0, 0, 0);
    checks++; if (moving !== 1'b0 || door_open !== 1'b0) begin
      errors++; $display("FAIL idle_before got moving=%b door=%b exp 0/0", moving, door_open); end
    fl = m_floor;
    seen = 1'b0;
    tick(0, 1, fl, 0); seen |= door_open;
    tick(0, 0, 0, 0); seen |= door_open;
    checks++; if (seen !== 1'b1) begin errors++; $display("FAIL same_floor_door got=%b exp=1", seen); end
    checks++; if (int'(floor_pos) != fl) begin errors++; $display("FAIL same_floor_pos got=%0d exp=%0d", floor_pos, fl); end
  endtask

  task automatic test_out_of_range();
    s_req_valid = 1'b1; s_req_floor = 3'd6;
    tick(0, 0, 0, 0);
    s_req_floor = 3'd7;
    tick(0, 0, 0, 0);
    s_req_valid = 1'b0;
    tick(0, 0, 0, 0);
    tick(0, 0, 0, 0);
    checks++; if (s_pending !== '0) begin errors++; $display("FAIL oor_pending got=%b exp=0", s_pending); end
    checks++; if (s_moving !== 1'b0 || s_door_open !== 1'b0 || s_arrive !== 1'b0) begin
      errors++; $display("FAIL oor_idle got mv=%b door=%b arr=%b exp 0/0/0", s_moving, s_door_open, s_arrive); end
    checks++; if (s_floor_pos !== '0 || s_dir_up !== 1'b1) begin
      errors++; $display("FAIL oor_pos got floor=%0d dir=%b exp 0/1", s_floor_pos, s_dir_up); end
    s_req_valid = 1'b1; s_req_floor = 3'd5;
    tick(0, 0, 0, 0);
    s_req_valid = 1'b0;
    checks++; if (s_pending !== 6'b100000) begin errors++; $display("FAIL inrange_pending got=%b exp=100000", s_pending); end
  endtask

  task automatic test_reset_mid_move();
    tick(1, 0, 0, 0);
    tick(0, 1, 7, 0);
    for (int k = 0; k < 100 && !(m_floor == 3 && m_mode == 1 && m_el == 1); k++) tick(0, 0, 0, 0);
    checks++; if (int'(floor_pos) != 3 || moving !== 1'b1) begin
      errors++; $display("FAIL pre_reset got floor=%0d moving=%b exp 3/1", floor_pos, moving); end
    tick(1, 1, 4, 0);
    checks++; if (floor_pos !== '0 || pending !== '0 || moving !== 1'b0 || door_open !== 1'b0) begin
      errors++; $display("FAIL mid_reset got floor=%0d pend=%b mv=%b door=%b exp 0/0/0/0",
                         floor_pos, pending, moving, door_open); end
    tick(0, 0, 0, 0);
    checks++; if (pending !== '0 || moving !== 1'b0) begin
      errors++; $display("FAIL reset_discard got pend=%b mv=%b exp 0/0", pending, moving); end
  endtask

`ifdef ELEV_DOOR_HOLD_EN
  task automatic test_door_hold();
    int cnt;
    tick(1, 0, 0, 0);
    tick(0, 1, 0, 0);
    tick(0, 0, 0, 0);
    cnt = door_open ? 1 : 0;
    for (int k = 0; k < 10; k++) begin tick(0, 0, 0, 1); if (door_open) cnt++; end
    for (int k = 0; k < 30; k++) begin tick(0, 0, 0, 0); if (door_open) cnt++; end
    checks++; if (cnt != 10 + DC) begin errors++; $display("FAIL door_hold_cycles got=%0d exp=%0d", cnt, 10 + DC); end
  endtask
`endif

  task automatic test_random();
    logic [FW+N+3:0] act, exp;
    bit v, h;
    int f;
    tick(1, 0, 0, 0);
    for (int k = 0; k < 600; k++) begin
      v = ($urandom_range(0, 9) < 3);
      f = $urandom_range(0, N - 1);
      h = 1'b0;
`ifdef ELEV_DOOR_HOLD_EN
      h = ($urandom_range(0, 15) == 0);
`endif
      tick(0, v, f, h);
      act = {floor_pos, pending, dir_up, moving, door_open, arrive};
      exp = {FW'(m_floor), pend_vec(), m_dir, (m_mode == 1 || m_mode == 2), (m_mode == 3), m_arr};
      checks++;
      if (act !== exp) begin
        errors++;
        if (errors < 20) $display("FAIL random_cycle%0d got=%h exp=%h", k, act, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_travel_to_5();
    test_scan_order();
    test_same_floor();
    test_out_of_range();
    test_reset_mid_move();
`ifdef ELEV_DOOR_HOLD_EN
    test_door_hold();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
